wordle_game_ctrl: RTL

Top-level game sequencer for the Wordle board. It builds a 5-letter guess from debounced single-cycle button pulses and hands the guess to the external scoring datapath over a req/ack handshake. It tracks the attempt count and declares win or lose. It sits between the button debouncers and the scorer/display logic, and exports one-hot state flags in the same style as the existing lock state machine.

---
 rtl/wordle_pkg.sv | 22 ++
 rtl/wordle_hold_timer.sv | 28 ++
 rtl/wordle_game_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/wordle_pkg.sv
// Wordle game controller shared types: one-hot states, letter bounds, score codes.
package wordle_pkg;

   typedef enum logic [5:0] {
      QI     = 6'b000001,
      QENTRY = 6'b000010,
      QCHECK = 6'b000100,
      QSHOW  = 6'b001000,
      QWIN   = 6'b010000,
      QLOSE  = 6'b100000
   } state_e;

   localparam int unsigned LETTER_A = 0;
   localparam int unsigned LETTER_Z = 25;

   typedef enum logic [1:0] {
      SC_GREY   = 2'b00,
      SC_YELLOW = 2'b01,
      SC_GREEN  = 2'b10
   } score_e;

endpackage

// File: rtl/wordle_hold_timer.sv
// Loadable down-counter; done is high once the count has drained to zero.
module wordle_hold_timer #(
   parameter int unsigned CYCLES = 16
) (
   input  logic Clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic done
);

   localparam int unsigned CW = $clog2(CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= CW'(CYCLES - 1);
      end else if (en && count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/wordle_game_ctrl.sv
// Wordle game sequencer: guess entry, scorer handshake, attempt tracking.
// Optional WORDLE_DICT_CHECK_EN adds score_invalid/bad_word rejection of guesses.
module wordle_game_ctrl
   import wordle_pkg::*;
#(
   parameter int unsigned WORD_LEN    = 5,
   parameter int unsigned LETTER_W    = 5,
   parameter int unsigned MAX_GUESSES = 6,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic                         Clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         letter_up,
   input  logic                         letter_down,
   input  logic                         next_pos,
   input  logic                         del,
   input  logic                         submit,
   input  logic                         score_ack,
   input  logic [2*WORD_LEN-1:0]        score_result,
`ifdef WORDLE_DICT_CHECK_EN
   input  logic                         score_invalid,
   output logic                         bad_word,
`endif
   output logic                         score_req,
   output logic [WORD_LEN*LETTER_W-1:0] guess_word,
   output logic [2:0]                   cursor,
   output logic [2:0]                   attempt_cnt,
   output logic [2*WORD_LEN-1:0]        last_score,
   output logic                         q_I,
   output logic                         q_Entry,
   output logic                         q_Check,
   output logic                         q_Show,
   output logic                         q_Win,
   output logic                         q_Lose
);

   localparam logic [2:0]          LAST = 3'(WORD_LEN - 1);
   localparam logic [LETTER_W-1:0] LA   = LETTER_W'(LETTER_A);
   localparam logic [LETTER_W-1:0] LZ   = LETTER_W'(LETTER_Z);

   state_e              state, state_nxt;
   logic [LETTER_W-1:0] letters [WORD_LEN];
   logic                ack_ok;
   logic                all_green;
   logic                last_try;
   logic                hold_load;
   logic                hold_done;

`ifdef WORDLE_DICT_CHECK_EN
   logic ack_bad;
   assign ack_ok  = score_ack & ~score_invalid;
   assign ack_bad = score_ack &  score_invalid;
`else
   assign ack_ok  = score_ack;
`endif

   always_comb begin
      all_green = 1'b1;
      for (int i = 0; i < WORD_LEN; i++) begin
         if (score_result[2*i +: 2] != SC_GREEN) all_green = 1'b0;
      end
   end

   assign last_try = (attempt_cnt + 3'd1) == 3'(MAX_GUESSES);

   always_comb begin
      state_nxt = state;
      hold_load = 1'b0;
      case (state)
         QI:     if (start) state_nxt = QENTRY;
         QENTRY: if (submit && cursor == LAST) state_nxt = QCHECK;
         QCHECK: begin
            if (ack_ok) begin
               if (all_green) begin
                  state_nxt = QWIN;
               end else if (last_try) begin
                  state_nxt = QLOSE;
               end else begin
                  state_nxt = QSHOW;
                  hold_load = 1'b1;
               end
            end
`ifdef WORDLE_DICT_CHECK_EN
            if (ack_bad) state_nxt = QENTRY;
`endif
         end
         QSHOW:       if (hold_done) state_nxt = QENTRY;
         QWIN, QLOSE: if (start) state_nxt = QENTRY;
         default:     state_nxt = QI;
      endcase
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) state <= QI;
      else        state <= state_nxt;
   end

   wordle_hold_timer #(.CYCLES(HOLD_CYCLES)) u_hold (
      .Clk   (Clk),
      .reset (reset),
      .load  (hold_load),
      .en    (state == QSHOW),
      .done  (hold_done)
   );

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < WORD_LEN; i++) letters[i] <= '0;
         cursor      <= '0;
         attempt_cnt <= '0;
         last_score  <= {WORD_LEN{SC_GREY}};
      end else begin
         case (state)
            QI, QWIN, QLOSE: begin
               if (start) begin
                  for (int i = 0; i < WORD_LEN; i++) letters[i] <= '0;
                  cursor      <= '0;
                  attempt_cnt <= '0;
                  last_score  <= {WORD_LEN{SC_GREY}};
               end
            end
            QENTRY: begin
               // submit wins the cycle even when it is rejected
               if (!submit) begin
                  if (del) begin
                     letters[cursor] <= '0;
                     if (cursor != '0) cursor <= cursor - 3'd1;
                  end else if (next_pos) begin
                     if (cursor != LAST) cursor <= cursor + 3'd1;
                  end else if (letter_up) begin
                     letters[cursor] <= (letters[cursor] == LZ) ? LA
                                      : letters[cursor] + 1'b1;
                  end else if (letter_down) begin
                     letters[cursor] <= (letters[cursor] == LA) ? LZ
                                      : letters[cursor] - 1'b1;
                  end
               end
            end
            QCHECK: begin
               if (ack_ok) begin
                  last_score  <= score_result;
                  attempt_cnt <= attempt_cnt + 3'd1;
               end
            end
            QSHOW: begin
               if (hold_done) begin
                  for (int i = 0; i < WORD_LEN; i++) letters[i] <= '0;
                  cursor <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef WORDLE_DICT_CHECK_EN
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) bad_word <= 1'b0;
      else        bad_word <= (state == QCHECK) && ack_bad;
   end
`endif

   always_comb begin
      guess_word = '0;
      for (int i = 0; i < WORD_LEN; i++) begin
         guess_word[i*LETTER_W +: LETTER_W] = letters[i];
      end
   end

   assign score_req = (state == QCHECK);
   assign q_I       = (state == QI);
   assign q_Entry   = (state == QENTRY);
   assign q_Check   = (state == QCHECK);
   assign q_Show    = (state == QSHOW);
   assign q_Win     = (state == QWIN);
   assign q_Lose    = (state == QLOSE);

endmodule
